// File: rtl/rhodonite_pkg.sv
// Shared RV32 decode constants: instruction field positions and the x0 index.
package rhodonite_pkg;

  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH  = 5;
  localparam int unsigned INSTR_WIDTH = 32;

  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RS2_MSB = 24;

  localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/operand_bypass.sv
// Per-port operand resolution: registers a writeback hit against the address
// being read this cycle, then picks captured wb data or file data next cycle,
// with a held x0 source forcing zero.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_rf_addr       address presented to the register file this cycle
//   i_src_addr      held source index of the bundle (x0 check)
//   i_wb_*          snoop of the register file write port
//   i_rf_data       registered read data from the file
//   o_operand       resolved operand
module operand_bypass
  import rhodonite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P = 32,
  parameter int unsigned ADDR_WIDTH_P = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH_P-1:0] i_rf_addr,
  input  logic [ADDR_WIDTH_P-1:0] i_src_addr,
  input  logic [ADDR_WIDTH_P-1:0] i_wb_addr,
  input  logic [DATA_WIDTH_P-1:0] i_wb_data,
  input  logic                    i_wb_enable,
  input  logic [DATA_WIDTH_P-1:0] i_rf_data,
  output logic [DATA_WIDTH_P-1:0] o_operand
);

  localparam logic [ADDR_WIDTH_P-1:0] X0_ADDR = ADDR_WIDTH_P'(X0_IDX);

  logic                    r_hit;
  logic [DATA_WIDTH_P-1:0] r_wb_data;
  logic [DATA_WIDTH_P-1:0] w_operand;

  // The file's registered read returns pre-write data when read and write
  // share an edge, so a same-cycle write to the read address is captured here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit     <= 1'b0;
      r_wb_data <= '0;
    end else begin
      r_hit     <= i_wb_enable && (i_wb_addr == i_rf_addr) && (i_rf_addr != X0_ADDR);
      r_wb_data <= i_wb_data;
    end
  end

  // x0 wins over both bypass and file content.
  always_comb begin
    w_operand = i_rf_data;
    if (r_hit) w_operand = r_wb_data;
    if (i_src_addr == X0_ADDR) w_operand = '0;
  end

  assign o_operand = w_operand;

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand stage ahead of register_file: one-entry holding register
// with valid/ready on both sides, register-file address steering, and
// writeback bypass / x0 forcing per source port.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_instr/i_pc/i_valid/o_ready   fetch-side handshake
//   o_rf_rd_addr_a/b           register file read addresses
//   i_rf_rd_data_a/b           register file read data (1-cycle latency)
//   i_wb_addr/data/enable      snoop of the register file write port
//   o_valid/i_ready            execute-side handshake
//   o_pc/o_instr/o_rd_addr     held instruction fields
//   o_rs1_data/o_rs2_data      resolved operands
module operand_fetch
  import rhodonite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P  = DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH_P  = ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH_P = INSTR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INSTR_WIDTH_P-1:0] i_instr,
  input  logic [INSTR_WIDTH_P-1:0] i_pc,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [ADDR_WIDTH_P-1:0]  o_rf_rd_addr_a,
  output logic [ADDR_WIDTH_P-1:0]  o_rf_rd_addr_b,
  input  logic [DATA_WIDTH_P-1:0]  i_rf_rd_data_a,
  input  logic [DATA_WIDTH_P-1:0]  i_rf_rd_data_b,
  input  logic [ADDR_WIDTH_P-1:0]  i_wb_addr,
  input  logic [DATA_WIDTH_P-1:0]  i_wb_data,
  input  logic                     i_wb_enable,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [INSTR_WIDTH_P-1:0] o_pc,
  output logic [INSTR_WIDTH_P-1:0] o_instr,
  output logic [ADDR_WIDTH_P-1:0]  o_rd_addr,
  output logic [DATA_WIDTH_P-1:0]  o_rs1_data,
  output logic [DATA_WIDTH_P-1:0]  o_rs2_data
);

  logic                     r_valid;
  logic [INSTR_WIDTH_P-1:0] r_pc;
  logic [INSTR_WIDTH_P-1:0] r_instr;
  logic [ADDR_WIDTH_P-1:0]  r_rs1;
  logic [ADDR_WIDTH_P-1:0]  r_rs2;
  logic [ADDR_WIDTH_P-1:0]  r_rd;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_transfer;
  logic [ADDR_WIDTH_P-1:0]  w_in_rs1;
  logic [ADDR_WIDTH_P-1:0]  w_in_rs2;
  logic [ADDR_WIDTH_P-1:0]  w_in_rd;
  logic [ADDR_WIDTH_P-1:0]  w_rf_addr_a;
  logic [ADDR_WIDTH_P-1:0]  w_rf_addr_b;

  assign w_in_rs1 = ADDR_WIDTH_P'(i_instr[RS1_MSB:RS1_LSB]);
  assign w_in_rs2 = ADDR_WIDTH_P'(i_instr[RS2_MSB:RS2_LSB]);
  assign w_in_rd  = ADDR_WIDTH_P'(i_instr[RD_MSB:RD_LSB]);

  assign w_ready    = !r_valid || i_ready;
  assign w_accept   = i_valid && w_ready;
  assign w_transfer = r_valid && i_ready;

  // Holding register; reset drops any held bundle and ignores a same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_rs1   <= w_in_rs1;
      r_rs2   <= w_in_rs2;
      r_rd    <= w_in_rd;
    end else if (w_transfer) begin
      r_valid <= 1'b0;
    end
  end

  // New sources while accepting; otherwise re-read the held ones every cycle.
  assign w_rf_addr_a = w_accept ? w_in_rs1 : r_rs1;
  assign w_rf_addr_b = w_accept ? w_in_rs2 : r_rs2;

  operand_bypass #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .ADDR_WIDTH_P (ADDR_WIDTH_P)
  ) u_bypass_a (
    .clk         (clk),
    .reset       (reset),
    .i_rf_addr   (w_rf_addr_a),
    .i_src_addr  (r_rs1),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .i_wb_enable (i_wb_enable),
    .i_rf_data   (i_rf_rd_data_a),
    .o_operand   (o_rs1_data)
  );

  operand_bypass #(
    .DATA_WIDTH_P (DATA_WIDTH_P),
    .ADDR_WIDTH_P (ADDR_WIDTH_P)
  ) u_bypass_b (
    .clk         (clk),
    .reset       (reset),
    .i_rf_addr   (w_rf_addr_b),
    .i_src_addr  (r_rs2),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .i_wb_enable (i_wb_enable),
    .i_rf_data   (i_rf_rd_data_b),
    .o_operand   (o_rs2_data)
  );

  assign o_ready        = w_ready;
  assign o_rf_rd_addr_a = w_rf_addr_a;
  assign o_rf_rd_addr_b = w_rf_addr_b;
  assign o_valid        = r_valid;
  assign o_pc           = r_pc;
  assign o_instr        = r_instr;
  assign o_rd_addr      = r_rd;

endmodule
